nand_page_reader: RTL and testbench

Data-out sequencer for the NAND flash interface. After the command/address sequencer has issued a read (00h, address cycles, 30h), this block waits for the device to go busy and then ready, then toggles RE to clock a programmable number of bytes off the 8-bit IO bus. Each byte is delivered to the downstream consumer through a valid/ready handshake with backpressure. It shares the NAND control pins with the command/address sequencer, and the top level muxes them by which block is active.

---
 rtl/nand_pkg.sv | 38 +++
 rtl/nand_rb_sync.sv | 30 +++
 rtl/nand_page_reader.sv | 210 +++++++++++++++++++++
 tb/tb_nand_page_reader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// -----------------------------------------------------------------------------
// nand_pkg
// Shared definitions for the NAND flash interface blocks.
//   - CPINS bit positions and the idle pin vector
//   - NAND command opcodes
//   - state encoding of the page reader
//   - small constant helper used for counter sizing
// -----------------------------------------------------------------------------
package nand_pkg;

    // CPINS bit positions: WE, CE and RE are active-low; CLE and ALE active-high
    localparam int unsigned PIN_WE  = 0;
    localparam int unsigned PIN_CE  = 1;
    localparam int unsigned PIN_CLE = 2;
    localparam int unsigned PIN_ALE = 3;
    localparam int unsigned PIN_RE  = 4;

    // {RE, ALE, CLE, CE, WE} with nothing asserted
    localparam logic [4:0] CPINS_IDLE = 5'b10011;

    localparam logic [7:0] CMD_READ_1 = 8'h00;
    localparam logic [7:0] CMD_READ_2 = 8'h30;
    localparam logic [7:0] CMD_PROG_1 = 8'h80;
    localparam logic [7:0] CMD_PROG_2 = 8'h10;

    localparam logic [2:0] RD_IDLE       = 3'd0;
    localparam logic [2:0] RD_WAIT_BUSY  = 3'd1;
    localparam logic [2:0] RD_WAIT_READY = 3'd2;
    localparam logic [2:0] RD_RE_LOW     = 3'd3;
    localparam logic [2:0] RD_RE_HIGH    = 3'd4;
    localparam logic [2:0] RD_DRAIN      = 3'd5;
    localparam logic [2:0] RD_DONE       = 3'd6;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// -----------------------------------------------------------------------------
// nand_rb_sync
// Two-flop synchronizer for the NAND R/B# pin. Resets to 1 (ready) so the
// reader never sees a spurious busy right after reset.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   rb_async in   raw R/B# from the pad (0 = busy)
//   rb_sync  out  synchronized R/B#
// -----------------------------------------------------------------------------
module nand_rb_sync (
    input  logic clk,
    input  logic rst,
    input  logic rb_async,
    output logic rb_sync
);

    logic rb_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_meta <= 1'b1;
            rb_sync <= 1'b1;
        end else begin
            rb_meta <= rb_async;
            rb_sync <= rb_meta;
        end
    end

endmodule

// File: rtl/nand_page_reader.sv
// -----------------------------------------------------------------------------
// nand_page_reader
// Data-out sequencer for the NAND interface. After a page read command has
// been issued elsewhere, waits for R/B# to go busy then ready, toggles RE to
// clock byteCount bytes off the IO bus, and hands each byte downstream via a
// valid/ready handshake with backpressure.
//
// Optional feature: define NAND_READ_TIMEOUT_EN to bound the ready wait to
// BUSY_TIMEOUT clocks (sets timeout and finishes without any RE pulses).
// Without it the ready wait is unbounded and timeout is tied to 0.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse starting a read-out (ignored while busy)
//   byteCount  in   bytes to read, sampled on start
//   readyBusy  in   NAND R/B#, asynchronous (0 = busy)
//   readline   in   NAND IO bus
//   CPINS      out  {RE, ALE, CLE, CE, WE}
//   dataOut    out  captured byte
//   dataValid  out  dataOut holds an unconsumed byte
//   dataReady  in   consumer accepts the byte
//   busy       out  read-out in progress
//   complete   out  last byte consumed; held until next start or rst
//   timeout    out  ready wait expired; held until next start or rst
//
// state          | meaning
// ---------------+------------------------------------------------------------
// RD_IDLE        | CE high, waiting for start
// RD_WAIT_BUSY   | waiting up to WB_WAIT clocks for R/B# to fall
// RD_WAIT_READY  | waiting for R/B# to rise (optionally bounded)
// RD_RE_LOW      | RE low; byte captured on the last cycle
// RD_RE_HIGH     | RE high; stalls here while the output register is blocked
// RD_DRAIN       | all bytes read, waiting for the consumer to take the rest
// RD_DONE        | one cycle, CE released, back to idle
// -----------------------------------------------------------------------------
module nand_page_reader
    import nand_pkg::*;
#(
    parameter int unsigned BYTE_W         = 12,
    parameter int unsigned RE_LOW_CYCLES  = 2,
    parameter int unsigned RE_HIGH_CYCLES = 2,
    parameter int unsigned WB_WAIT        = 8,
    parameter int unsigned BUSY_TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] byteCount,
    input  logic              readyBusy,
    input  logic [7:0]        readline,
    output logic [4:0]        CPINS,
    output logic [7:0]        dataOut,
    output logic              dataValid,
    input  logic              dataReady,
    output logic              busy,
    output logic              complete,
    output logic              timeout
);

`ifdef NAND_READ_TIMEOUT_EN
    localparam int unsigned TO_EN = 1;
`else
    localparam int unsigned TO_EN = 0;
`endif

    // One phase counter serves WB_WAIT, RE low/high and, when enabled, the
    // ready timeout: these waits never overlap. With the timeout disabled,
    // BUSY_TIMEOUT does not widen the counter.
    localparam int unsigned PH_MAX = max_u(max_u(WB_WAIT, RE_LOW_CYCLES),
                                           max_u(RE_HIGH_CYCLES, TO_EN * BUSY_TIMEOUT));
    localparam int unsigned PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [PH_W-1:0]   ph_cnt;
    logic [BYTE_W-1:0] rem_cnt;
    logic [7:0]        cap_data;
    logic              cap_full;
    logic              ce_n;
    logic              re_n;
    logic              rbS;
    logic              ph_zero;
    logic              out_free;
    logic              capture;
    logic              rem_zero;

    nand_rb_sync u_rb_sync (
        .clk      (clk),
        .rst      (rst),
        .rb_async (readyBusy),
        .rb_sync  (rbS)
    );

    assign ph_zero  = (ph_cnt == '0);
    assign rem_zero = (rem_cnt == '0);
    // Output register can take a byte this cycle: empty, or being consumed.
    assign out_free = !dataValid || dataReady;
    assign capture  = (state == RD_RE_LOW) && ph_zero;

`ifdef NAND_READ_TIMEOUT_EN
    logic to_hit;
    assign to_hit = (state == RD_WAIT_READY) && !rbS && ph_zero;
`endif

    always_comb begin
        next_state = state;
        case (state)
            RD_IDLE:       if (start) next_state = RD_WAIT_BUSY;
            RD_WAIT_BUSY:  if (!rbS || ph_zero) next_state = RD_WAIT_READY;
            RD_WAIT_READY: begin
                if (rbS)
                    next_state = rem_zero ? RD_DONE : RD_RE_LOW;
`ifdef NAND_READ_TIMEOUT_EN
                else if (ph_zero)
                    next_state = RD_DONE;
`endif
            end
            RD_RE_LOW:     if (ph_zero) next_state = RD_RE_HIGH;
            RD_RE_HIGH: begin
                if (ph_zero) begin
                    if (rem_zero)
                        next_state = RD_DRAIN;
                    else if (out_free)
                        next_state = RD_RE_LOW;
                end
            end
            // Capture register must be empty too, or a byte could still be
            // waiting to move into dataOut.
            RD_DRAIN:      if (!dataValid && !cap_full) next_state = RD_DONE;
            RD_DONE:       next_state = RD_IDLE;
            default:       next_state = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RD_IDLE;
            ph_cnt    <= '0;
            rem_cnt   <= '0;
            cap_data  <= '0;
            cap_full  <= 1'b0;
            ce_n      <= 1'b1;
            re_n      <= 1'b1;
            dataOut   <= '0;
            dataValid <= 1'b0;
            busy      <= 1'b0;
            complete  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= next_state;
            re_n  <= (next_state != RD_RE_LOW);

            if (next_state != state) begin
                case (next_state)
                    RD_WAIT_BUSY:  ph_cnt <= PH_W'(WB_WAIT - 1);
`ifdef NAND_READ_TIMEOUT_EN
                    RD_WAIT_READY: ph_cnt <= PH_W'(BUSY_TIMEOUT - 1);
`endif
                    RD_RE_LOW:     ph_cnt <= PH_W'(RE_LOW_CYCLES - 1);
                    RD_RE_HIGH:    ph_cnt <= PH_W'(RE_HIGH_CYCLES - 1);
                    default:       ph_cnt <= '0;
                endcase
            end else if (!ph_zero) begin
                ph_cnt <= ph_cnt - 1'b1;
            end

            if (state == RD_IDLE && start) begin
                rem_cnt  <= byteCount;
                complete <= 1'b0;
                timeout  <= 1'b0;
                busy     <= 1'b1;
                ce_n     <= 1'b0;
            end

            if (next_state == RD_DONE && state != RD_DONE) begin
                busy     <= 1'b0;
                ce_n     <= 1'b1;
                complete <= 1'b1;
            end

`ifdef NAND_READ_TIMEOUT_EN
            if (to_hit) timeout <= 1'b1;
`endif

            if (dataValid && dataReady) dataValid <= 1'b0;

            if (cap_full && out_free) begin
                dataOut   <= cap_data;
                dataValid <= 1'b1;
                cap_full  <= 1'b0;
            end

            // RE_LOW is only entered once the capture register will be empty,
            // so this never collides with the transfer above.
            if (capture) begin
                cap_data <= readline;
                cap_full <= 1'b1;
                if (!rem_zero) rem_cnt <= rem_cnt - 1'b1;
            end
        end
    end

    assign CPINS[PIN_WE]  = 1'b1;
    assign CPINS[PIN_CE]  = ce_n;
    assign CPINS[PIN_CLE] = 1'b0;
    assign CPINS[PIN_ALE] = 1'b0;
    assign CPINS[PIN_RE]  = re_n;

endmodule

// File: tb/tb_nand_page_reader.sv
// -----------------------------------------------------------------------------
// tb_nand_page_reader
// Directed bench for nand_page_reader. A negedge monitor plays the NAND
// device (R/B# window, IO data on each RE fall) and the consumer (dataReady
// with an optional pause), and logs RE falls, accepted bytes and the rise of
// complete. A vector table drives the main read-outs; reset and timeout
// corner cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_nand_page_reader;

    localparam int BYTE_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [BYTE_W-1:0] byteCount = '0;
    logic              readyBusy = 1'b1;
    logic [7:0]        readline = 8'h00;
    logic [4:0]        CPINS;
    logic [7:0]        dataOut;
    logic              dataValid;
    logic              dataReady = 1'b1;
    logic              busy;
    logic              complete;
    logic              timeout;

    nand_page_reader #(
        .BYTE_W         (BYTE_W),
        .RE_LOW_CYCLES  (2),
        .RE_HIGH_CYCLES (2),
        .WB_WAIT        (8),
        .BUSY_TIMEOUT   (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byteCount (byteCount),
        .readyBusy (readyBusy),
        .readline  (readline),
        .CPINS     (CPINS),
        .dataOut   (dataOut),
        .dataValid (dataValid),
        .dataReady (dataReady),
        .busy      (busy),
        .complete  (complete),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;            // byteCount
        int rb_len;       // clocks R/B# held low after start (0 = never falls)
        int stall_after;  // consumer pauses after this many bytes (0 = never)
        int stall_len;    // pause length in clocks
        int exp_first;    // clocks from start to first RE fall (n=0: to complete)
        int exp_stall;    // 1 = a stretched RE gap is required
    } vec_t;

    logic [7:0] mem [8];
    vec_t       vecs [5];

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int rb_from = 0;
    int rb_len = 0;
    int re_falls = 0;
    int fall_cyc [16];
    logic [7:0] rx [16];
    int rx_n = 0;
    int last_acc = -1;
    int cmp_cyc = -1;
    int st_cyc = 0;
    int stall_after = 0;
    int stall_len = 0;
    int stall_left = 0;
    logic re_prev = 1'b1;
    logic cmp_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        readyBusy = (rb_len > 0 && cyc > rb_from && cyc <= rb_from + rb_len) ? 1'b0 : 1'b1;
        if (re_prev && !CPINS[4]) begin
            if (re_falls < 16) fall_cyc[re_falls] = cyc;
            readline = mem[re_falls % 8];
            re_falls = re_falls + 1;
        end
        re_prev = CPINS[4];
        if (stall_left > 0) begin
            dataReady = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            dataReady = 1'b1;
        end
        if (dataValid && dataReady) begin
            if (rx_n < 16) rx[rx_n] = dataOut;
            rx_n = rx_n + 1;
            last_acc = cyc;
            if (rx_n == stall_after) stall_left = stall_len;
        end
        if (complete && !cmp_prev) cmp_cyc = cyc;
        cmp_prev = complete;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic kick(input int n, input int rbl);
        @(negedge clk); #1;
        re_falls = 0; rx_n = 0; cmp_cyc = -1; last_acc = -1;
        byteCount = BYTE_W'(n);
        start = 1'b1;
        st_cyc = cyc;
        rb_from = cyc;
        rb_len = rbl;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_complete(input int limit);
        int guard = 0;
        while (cmp_cyc < 0 && guard < limit) begin
            @(negedge clk); #1;
            guard++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int gap;
        int max_gap;
        logic all4;
        wait_idle();
        stall_after = v.stall_after;
        stall_len = v.stall_len;
        kick(v.n, v.rb_len);
        chk({tag, ".ce_low"}, {31'd0, CPINS[1]}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        wait_complete(2000);
        chk({tag, ".completed"}, (cmp_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk({tag, ".bytes"}, rx_n, v.n);
        for (int i = 0; i < v.n && i < 16; i++)
            chk($sformatf("%s.byte%0d", tag, i), {24'd0, rx[i]}, {24'd0, mem[i]});
        chk({tag, ".re_pulses"}, re_falls, v.n);
        if (v.n > 0) begin
            chk({tag, ".first_re"}, fall_cyc[0] - st_cyc, v.exp_first);
            chk({tag, ".complete_lat"}, cmp_cyc - last_acc, 32'd2);
        end else begin
            chk({tag, ".complete_off"}, cmp_cyc - st_cyc, v.exp_first);
        end
        if (v.n > 1) begin
            max_gap = 0;
            all4 = 1'b1;
            for (int i = 1; i < v.n && i < 16; i++) begin
                gap = fall_cyc[i] - fall_cyc[i-1];
                if (gap > max_gap) max_gap = gap;
                if (gap != 4) all4 = 1'b0;
            end
            if (v.exp_stall != 0)
                chk({tag, ".re_stalled"}, (max_gap > 4) ? 32'd1 : 32'd0, 32'd1);
            else
                chk({tag, ".re_period4"}, {31'd0, all4}, 32'd1);
        end
        chk({tag, ".pins_idle"}, {27'd0, CPINS}, 32'h13);
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, ".timeout"}, {31'd0, timeout}, 32'd0);
        stall_after = 0;
        stall_len = 0;
    endtask

    initial begin
        int guard;
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
        mem[4] = 8'h5A; mem[5] = 8'hC3; mem[6] = 8'h81; mem[7] = 8'h7E;

        vecs[0] = '{n: 4, rb_len: 20, stall_after: 0, stall_len: 0,  exp_first: 24, exp_stall: 0};
        vecs[1] = '{n: 3, rb_len: 20, stall_after: 1, stall_len: 10, exp_first: 24, exp_stall: 1};
        vecs[2] = '{n: 0, rb_len: 20, stall_after: 0, stall_len: 0,  exp_first: 24, exp_stall: 0};
        vecs[3] = '{n: 2, rb_len: 0,  stall_after: 0, stall_len: 0,  exp_first: 10, exp_stall: 0};
        vecs[4] = '{n: 5, rb_len: 6,  stall_after: 0, stall_len: 0,  exp_first: 10, exp_stall: 0};

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.cpins", {27'd0, CPINS}, 32'h13);
        chk("rst.dataOut", {24'd0, dataOut}, 32'd0);
        chk("rst.dataValid", {31'd0, dataValid}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.complete", {31'd0, complete}, 32'd0);
        chk("rst.timeout", {31'd0, timeout}, 32'd0);

        // start on the same edge as rst: rst wins
        byteCount = BYTE_W'(3);
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst_start.busy", {31'd0, busy}, 32'd0);
        chk("rst_start.cpins", {27'd0, CPINS}, 32'h13);
        @(negedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_start.still_idle", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset while byte 2 of 5 is being clocked out
        wait_idle();
        kick(5, 6);
        guard = 0;
        while (re_falls < 2 && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("midrst.reached_byte2", re_falls, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.cpins", {27'd0, CPINS}, 32'h13);
        chk("midrst.dataValid", {31'd0, dataValid}, 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("midrst.no_complete", {31'd0, complete}, 32'd0);
        chk("midrst.no_extra_re", re_falls, 32'd2);
        run_vec(vecs[4], "after_rst");

        // R/B# held low well past 50 clocks
        wait_idle();
`ifdef NAND_READ_TIMEOUT_EN
        kick(2, 1000);
        wait_complete(400);
        chk("tmo.completed", (cmp_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk("tmo.timeout", {31'd0, timeout}, 32'd1);
        chk("tmo.complete", {31'd0, complete}, 32'd1);
        chk("tmo.ce_high", {31'd0, CPINS[1]}, 32'd1);
        chk("tmo.no_re", re_falls, 32'd0);
        chk("tmo.latency", cmp_cyc - st_cyc, 32'd54);
        rb_len = 0;
`else
        kick(2, 120);
        wait_complete(400);
        chk("longwait.completed", (cmp_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk("longwait.timeout", {31'd0, timeout}, 32'd0);
        chk("longwait.bytes", rx_n, 32'd2);
        chk("longwait.first_re", fall_cyc[0] - st_cyc, 32'd124);
        chk("longwait.byte0", {24'd0, rx[0]}, 32'hA5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
